// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
// Hazard and sequencing control for a five-stage pipeline. It handles:
//   - load-use stalls
//   - jump and taken-branch flushes
//   - an iterative multiplier start/busy/HI-LO write-back tracker
//   - halt, with a drain of any multiply that is in flight
//
// Ports
//   clk              single clock, rising edge
//   rst              asynchronous active-low reset
//   ex_mem_read      instruction in EX is a load
//   ex_rt            destination register of that load
//   id_rs, id_rt     source registers of the instruction in ID
//   id_uses_rt       ID instruction reads rt
//   id_jump          ID holds J/JAL/JR
//   ex_branch_taken  branch in EX resolved taken
//   id_mult          ID holds MULT/MULTU
//   id_mult_signed   1 = MULT, 0 = MULTU
//   id_reads_hilo    ID reads HI or LO
//   id_halt          ID holds HALT
//   pc_en, ifid_en   PC and IF/ID update enables
//   ifid_flush       load a bubble into IF/ID
//   idex_flush       load a bubble into ID/EX
//   mul_go           one-cycle multiplier start pulse
//   mul_signed       signedness latched at the last start
//   mul_busy         multiply in flight
//   hilo_we          HI/LO write strobe
//   halted           core halted (left only through reset)
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       ex_branch_taken,
  input  logic       id_mult,
  input  logic       id_mult_signed,
  input  logic       id_reads_hilo,
  input  logic       id_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       mul_go,
  output logic       mul_signed,
  output logic       mul_busy,
  output logic       hilo_we,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [5:0] MCNT_LOAD = 6'(MUL_CYCLES - 1);

  state_t     state_r;
  state_t     state_s;
  logic       busy_r;
  logic [5:0] mcnt_r;
  logic       signed_r;

  logic       load_use_s;
  logic       mul_hz_s;
  logic       hilo_we_s;
  logic       mul_go_s;
  logic       pc_en_s;
  logic       ifid_en_s;
  logic       ifid_flush_s;
  logic       idex_flush_s;

  // Hazard terms; register 0 never carries a real dependency.
  assign load_use_s = ex_mem_read & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mul_hz_s   = busy_r & (id_mult | id_reads_hilo);
  assign hilo_we_s  = busy_r & (mcnt_r == 6'd0);

  // Next-state and pipeline control decode, priority branch > stall > jump.
  always_comb begin
    state_s      = state_r;
    pc_en_s      = 1'b0;
    ifid_en_s    = 1'b0;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    mul_go_s     = 1'b0;
    case (state_r)
      S_RUN: begin
        mul_go_s = id_mult & ~busy_r & ~ex_branch_taken & ~load_use_s;
        if (ex_branch_taken) begin
          pc_en_s      = 1'b1;
          ifid_en_s    = 1'b1;
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end else if (mul_hz_s || load_use_s) begin
          idex_flush_s = 1'b1;
        end else if (id_jump) begin
          pc_en_s      = 1'b1;
          ifid_en_s    = 1'b1;
          ifid_flush_s = 1'b1;
        end else begin
          pc_en_s   = 1'b1;
          ifid_en_s = 1'b1;
          // Halt is only honoured on an otherwise quiet cycle.
          if (id_halt) begin
            state_s = busy_r ? S_DRAIN : S_HALTED;
          end else begin
            state_s = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        idex_flush_s = 1'b1;
        if (hilo_we_s) begin
          state_s = S_HALTED;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_HALTED: begin
        idex_flush_s = 1'b1;
      end
      default: begin
        idex_flush_s = 1'b1;
        state_s      = S_RUN;
      end
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Multiply tracker: start loads the counter, busy drops after the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r   <= 1'b0;
      mcnt_r   <= 6'd0;
      signed_r <= 1'b0;
    end else if (mul_go_s) begin
      busy_r   <= 1'b1;
      mcnt_r   <= MCNT_LOAD;
      signed_r <= id_mult_signed;
    end else if (busy_r) begin
      if (mcnt_r == 6'd0) begin
        busy_r <= 1'b0;
      end else begin
        mcnt_r <= mcnt_r - 6'd1;
      end
    end
  end

  // The decode is combinational, so gate it with rst to hold every output low in reset.
  assign pc_en      = rst & pc_en_s;
  assign ifid_en    = rst & ifid_en_s;
  assign ifid_flush = rst & ifid_flush_s;
  assign idex_flush = rst & idex_flush_s;
  assign mul_go     = rst & mul_go_s;
  assign mul_signed = signed_r;
  assign mul_busy   = busy_r;
  assign hilo_we    = hilo_we_s;
  assign halted     = (state_r == S_HALTED);

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 32: iterative multiplier latency in cycles; legal range 2..64.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 ex_mem_read  in  1  the instruction in EX is a load.
REQ-005 ex_rt  in  5  destination register of the load in EX.
REQ-006 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-007 id_uses_rt  in  1  the instruction in ID reads rt.
REQ-008 id_jump  in  1  ID holds J/JAL/JR.
REQ-009 ex_branch_taken  in  1  the branch in EX resolved taken.
REQ-010 id_mult, id_mult_signed  in  1 each  ID holds MULT (signed=1) or MULTU (signed=0).
REQ-011 id_reads_hilo  in  1  ID reads HI or LO.
REQ-012 id_halt  in  1  ID holds HALT.
REQ-013 pc_en, ifid_en  out  1 each  PC and IF/ID register update enables.
REQ-014 ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID or ID/EX.
REQ-015 mul_go  out  1  one-cycle start pulse to the multiplier; mul_signed  out  1  latched signedness.
REQ-016 mul_busy  out  1  a multiply is in flight; hilo_we  out  1  HI/LO write strobe.
REQ-017 halted  out  1  the core is halted.

Function
REQ-018 Control FSM states are RUN, DRAIN and HALTED; the multiply tracker has a busy flag and a 6-bit down-counter mcnt.
REQ-019 load_use = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).
REQ-020 mul_hz = mul_busy & (id_mult | id_reads_hilo).
REQ-021 In RUN, cycle priority: ex_branch_taken > mul_hz > load_use > id_jump > normal.
REQ-022 Branch taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; no mul_go and no halt take effect that cycle.
REQ-023 mul_hz or load_use: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
REQ-024 Jump only: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0.
REQ-025 Normal: pc_en=1, ifid_en=1, both flushes 0.
REQ-026 mul_go=1 combinationally when state is RUN, id_mult=1, mul_busy=0, ex_branch_taken=0 and load_use=0; on the same edge mul_signed latches id_mult_signed.
REQ-027 On the edge after mul_go: busy is set to 1 and mcnt is loaded with MUL_CYCLES-1.
REQ-028 While busy, mcnt decrements by 1 per cycle.
REQ-029 hilo_we = busy & (mcnt == 0); busy clears on that edge, so mul_busy lasts exactly MUL_CYCLES cycles.
REQ-030 A new id_mult may issue mul_go on the first cycle busy=0 (back-to-back issue has a gap of zero cycles); mul_signed holds its value between issues.
REQ-031 An id_halt in RUN with no branch, stall or flush condition:
- mul_busy=0: next state is HALTED.
- otherwise: next state is DRAIN.
REQ-032 DRAIN goes to HALTED on the edge where hilo_we=1.
REQ-033 In DRAIN and HALTED: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, mul_go=0.
REQ-034 halted=1 only in HALTED; HALTED exits only through reset.

Reset
REQ-035 While rst=0, independent of clk: state=RUN, busy=0, mcnt=0, mul_signed=0.
REQ-036 While rst=0, all outputs are 0, including pc_en and ifid_en.
REQ-037 Reset during a multiply aborts it; no hilo_we is produced afterwards.
REQ-038 On the first edge after rst rises, operation follows the RUN rules.

Verification
REQ-039 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; repeat with ex_rt=0 -> no stall.
REQ-040 Multiply (MUL_CYCLES=32): id_mult=1, id_mult_signed=1 at cycle t -> mul_go at t, mul_signed=1 from t+1, mul_busy over t+1..t+32, hilo_we at t+32 only; MFHI held in ID is stalled over t+1..t+32.
REQ-041 Branch vs stall: ex_branch_taken=1 with load_use=1 and id_mult=1 in the same cycle -> ifid_flush=idex_flush=1, pc_en=1, mul_go=0.
REQ-042 Halt drain: id_halt at cycle 5 of a 32-cycle multiply -> DRAIN until hilo_we, HALTED and halted=1 on the next cycle, pc_en=0 thereafter.
REQ-043 Mid-op reset: rst=0 at cycle 10 of a multiply -> mul_busy=0 immediately, and no hilo_we within 40 cycles after release.
REQ-044 Jump: id_jump=1 alone -> ifid_flush=1, pc_en=1, idex_flush=0 for one cycle.
